// File: rtl/control_ws.sv
// control_ws: VeriRISC control sequencer with memory wait states,
// timeout, halt/resume, single-step gating and a retired-instruction count.
module control_ws #(
  parameter int FAST_MODE = 0,
  parameter int USE_READY = 0,
  parameter int MAX_WAIT  = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             step_en,
  input  logic             step,
  input  logic             resume,
  output logic             load_ac,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             load_ir,
  output logic             halt,
  output logic             bus_err,
  output logic             stalled,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  state_t     st;
  state_t     nxt;
  opcode_t    op;
  logic [7:0] wait_cnt;
  logic       alu_op;
  logic       stall_pt;
  logic       stall;
  logic       timeout;
  logic       retire;

  assign op     = opcode_t'(opcode);
  assign alu_op = (op == ADD) || (op == AND) ||
                  (op == XOR) || (op == LDA);

  always_comb begin
    stall_pt = 1'b0;
    case (st)
      INST_FETCH: stall_pt = 1'b1;
      OP_FETCH:   stall_pt = alu_op;
      STORE:      stall_pt = (op == STO);
      default:    stall_pt = 1'b0;
    endcase
  end

  assign stall   = (USE_READY != 0) && stall_pt && !mem_ready;
  assign timeout = (MAX_WAIT != 0) && stall &&
                   (wait_cnt == 8'(MAX_WAIT));
  assign stalled = stall;
  assign state   = st;

  always_comb begin
    nxt    = st;
    retire = 1'b0;
    case (st)
      INST_ADDR:
        if (!step_en || step) nxt = INST_FETCH;
      INST_FETCH: nxt = INST_LOAD;
      INST_LOAD:  nxt = (FAST_MODE != 0) ? OP_ADDR : IDLE;
      IDLE:       nxt = OP_ADDR;
      OP_ADDR: begin
        if (op == HLT) begin
          nxt    = HALTED;
          retire = 1'b1;
        end else begin
          nxt = OP_FETCH;
        end
      end
      OP_FETCH: nxt = ALU_OP;
      ALU_OP:   nxt = STORE;
      STORE: begin
        nxt    = INST_ADDR;
        retire = 1'b1;
      end
      HALTED:
        if (resume) nxt = INST_ADDR;
      default: nxt = INST_ADDR;
    endcase
    // a wait state freezes the sequence; a timeout aborts to HALTED
    if (stall) begin
      nxt    = timeout ? HALTED : st;
      retire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      st        <= INST_ADDR;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      st <= nxt;
      if (stall && !timeout) wait_cnt <= wait_cnt + 8'd1;
      else                   wait_cnt <= '0;
      if (timeout)                    bus_err <= 1'b1;
      else if (st == HALTED && resume) bus_err <= 1'b0;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    load_ac = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    case (st)
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (op == HLT);
      end
      OP_FETCH: mem_rd = alu_op;
      ALU_OP: begin
        mem_rd  = alu_op;
        load_ac = alu_op;
        inc_pc  = (op == SKZ) && zero;
        load_pc = (op == JMP);
      end
      STORE: begin
        mem_rd  = alu_op;
        load_ac = alu_op;
        mem_wr  = (op == STO);
        load_pc = (op == JMP);
        inc_pc  = (op == JMP);
      end
      HALTED:  halt = 1'b1;
      default: halt = 1'b0;
    endcase
  end

endmodule

// File: doc/control_ws.md
Name: control_ws

Overview:
- Parametrised successor to the fixed 8-state VeriRISC sequencer. Generates the same per-state control strobes for the accumulator datapath.
- Adds:
  - memory wait-state handshake with timeout
  - optional IDLE-skip fast mode
  - a held HALTED state with resume
  - single-step gating
  - a retired-instruction counter
- Sits between the instruction register / opcode decode and the PC, AC, IR and memory enables.

Parameters:
- FAST_MODE, 0, 1 = skip IDLE (INST_LOAD goes straight to OP_ADDR).
- USE_READY, 0, 1 = memory stall on mem_ready; 0 = mem_ready ignored (zero-wait memory).
- MAX_WAIT, 0, stalled cycles tolerated before bus error; 0 = no timeout. Range 0..255.
- CNT_W, 16, width of instr_cnt.

Ports:
- clk  in  1  rising-edge clock
- rst_  in  1  synchronous active-low reset
- opcode  in  3  opcode_t: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
- zero  in  1  accumulator-zero flag
- mem_ready  in  1  memory access complete this cycle
- step_en  in  1  single-step mode enable
- step  in  1  one-cycle pulse: release one instruction
- resume  in  1  one-cycle pulse: leave HALTED
- load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir  out  1 each  datapath strobes
- halt  out  1  processor halted / halting
- bus_err  out  1  sticky memory-timeout flag
- stalled  out  1  current cycle is a wait state
- state  out  4  present state encoding
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7, HALTED=8. Unused codes go to INST_ADDR.
- Reset: when rst_=0 at a clk edge:
  - state=INST_ADDR, instr_cnt=0, bus_err=0, wait counter=0
  - reset overrides all other inputs, including resume and step
  - all combinational outputs are then 0 (INST_ADDR decode)
- Strobes are Moore/Mealy-decoded from the present state and opcode. ALUOP = {ADD, AND, XOR, LDA}.
  - INST_ADDR: none
  - INST_FETCH: mem_rd
  - INST_LOAD: mem_rd, load_ir
  - IDLE: mem_rd, load_ir
  - OP_ADDR: inc_pc; halt if HLT
  - OP_FETCH: mem_rd if ALUOP
  - ALU_OP: mem_rd and load_ac if ALUOP; inc_pc if SKZ&&zero; load_pc if JMP
  - STORE: mem_rd and load_ac if ALUOP; mem_wr if STO; load_pc and inc_pc if JMP
  - HALTED: halt=1 only
- Transitions:
  - INST_ADDR -> INST_FETCH when (!step_en || step); otherwise hold.
  - INST_LOAD -> IDLE, or -> OP_ADDR if FAST_MODE=1.
  - OP_ADDR -> HALTED if opcode==HLT; otherwise -> OP_FETCH.
  - Remaining states advance in order; STORE -> INST_ADDR.
  - HALTED -> INST_ADDR on resume; otherwise hold.
- Wait states (USE_READY=1 only):
  - Stall points: INST_FETCH always; OP_FETCH when ALUOP; STORE when STO.
  - At a stall point with mem_ready=0: hold state, hold all strobes unchanged, stalled=1, wait counter +1.
  - With mem_ready=1: advance normally and clear the wait counter.
  - The wait counter also clears on every state change.
- Timeout: when MAX_WAIT>0, stalled, mem_ready=0 and the wait counter == MAX_WAIT:
  - next state = HALTED and bus_err <= 1
  - if mem_ready=1 arrives in that same cycle, ready wins: normal advance, no error
- Resume: clears bus_err and restarts at INST_ADDR. The PC is untouched, so the instruction is refetched. resume outside HALTED is ignored.
- step while step_en=0, or outside INST_ADDR, is ignored. Deasserting step_en while holding in INST_ADDR releases on the next cycle.
- instr_cnt increments (mod 2^CNT_W, wrapping silently) on:
  - the STORE -> INST_ADDR transition
  - the OP_ADDR -> HALTED transition
  - not on timeout entry to HALTED
- Cycle counts, no stalls:
  - 8 cycles per instruction (FAST_MODE=0)
  - 7 cycles per instruction (FAST_MODE=1)

Test Plan:
- Reset mid-STORE with opcode=STO: drive rst_=0 for 1 cycle -> next cycle state=0, all strobes 0, instr_cnt=0; rst_=1 -> state sequence 0,1,2,3,4,5,6,7 over 8 cycles.
- opcode=ADD, FAST_MODE=0, 3 instructions -> state 3 never skipped, load_ac=1 in states 6 and 7, instr_cnt=3 after 24 cycles. Repeat with FAST_MODE=1 -> state 3 never seen, instr_cnt=3 after 21 cycles.
- opcode=SKZ, zero=1 -> inc_pc=1 in OP_ADDR and ALU_OP. zero=0 -> inc_pc only in OP_ADDR. opcode=JMP -> load_pc in ALU_OP and STORE, inc_pc in STORE.
- USE_READY=1, MAX_WAIT=4, opcode=STO, mem_ready=0 for 3 cycles in STORE then 1 -> mem_wr held 4 cycles, stalled=1 for 3, no bus_err. Same with mem_ready held 0 -> HALTED after 5 stalled cycles, bus_err=1, instr_cnt unchanged; resume pulse -> state=0, bus_err=0.
- opcode=HLT -> halt=1 in OP_ADDR, state=8 next, instr_cnt+1, halt stays 1 for 20 cycles. resume -> state=0.
- step_en=1 -> state holds 0 for 10 cycles. One step pulse -> exactly one 8-cycle instruction executes, then state holds at 0 again. CNT_W=2 after 4 instructions -> instr_cnt wraps to 0.
